// File: rtl/sha256_round_sequencer.sv
// Iterative SHA-256 compression controller: drives an external single-round stage for
// 64 rounds, then applies the feed-forward add and hands the digest out over valid/ready.
module sha256_round_sequencer #(
  parameter bit FEED_FWD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [255:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy,
  output logic [31:0]  dg_k,
  output logic [511:0] dg_rx_w,
  output logic [255:0] dg_rx_state,
  input  logic [511:0] dg_tx_w,
  input  logic [255:0] dg_tx_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  logic [5:0]     r_rnd;
  logic [511:0]   r_blk;
  logic [255:0]   r_ist;
  logic           r_out_valid;
  logic [255:0]   r_out_digest;
  logic [255:0]   w_final;

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  k_rom = 32'h428a2f98; 6'd1:  k_rom = 32'h71374491; 6'd2:  k_rom = 32'hb5c0fbcf; 6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b; 6'd5:  k_rom = 32'h59f111f1; 6'd6:  k_rom = 32'h923f82a4; 6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98; 6'd9:  k_rom = 32'h12835b01; 6'd10: k_rom = 32'h243185be; 6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74; 6'd13: k_rom = 32'h80deb1fe; 6'd14: k_rom = 32'h9bdc06a7; 6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1; 6'd17: k_rom = 32'hefbe4786; 6'd18: k_rom = 32'h0fc19dc6; 6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f; 6'd21: k_rom = 32'h4a7484aa; 6'd22: k_rom = 32'h5cb0a9dc; 6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152; 6'd25: k_rom = 32'ha831c66d; 6'd26: k_rom = 32'hb00327c8; 6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3; 6'd29: k_rom = 32'hd5a79147; 6'd30: k_rom = 32'h06ca6351; 6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85; 6'd33: k_rom = 32'h2e1b2138; 6'd34: k_rom = 32'h4d2c6dfc; 6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354; 6'd37: k_rom = 32'h766a0abb; 6'd38: k_rom = 32'h81c2c92e; 6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1; 6'd41: k_rom = 32'ha81a664b; 6'd42: k_rom = 32'hc24b8b70; 6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819; 6'd45: k_rom = 32'hd6990624; 6'd46: k_rom = 32'hf40e3585; 6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116; 6'd49: k_rom = 32'h1e376c08; 6'd50: k_rom = 32'h2748774c; 6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3; 6'd53: k_rom = 32'h4ed8aa4a; 6'd54: k_rom = 32'h5b9cca4f; 6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee; 6'd57: k_rom = 32'h78a5636f; 6'd58: k_rom = 32'h84c87814; 6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa; 6'd61: k_rom = 32'ha4506ceb; 6'd62: k_rom = 32'hbef9a3f7; 6'd63: k_rom = 32'hc67178f2;
      default: k_rom = 32'h00000000;
    endcase
  endfunction

  // Eight independent 32-bit adds; carries never cross word boundaries.
  function automatic logic [255:0] word_add(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] s;
    s = 256'd0;
    for (int i = 0; i < 8; i++) begin
      s[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    end
    return s;
  endfunction

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN) || (r_state == S_FINISH);
  assign out_valid  = r_out_valid;
  assign out_digest = r_out_digest;
  assign w_final    = FEED_FWD ? word_add(r_ist, dg_tx_state) : dg_tx_state;

  // Round-stage drive: round 0 seeds from the captured job, later rounds loop the stage back.
  always_comb begin
    dg_k        = k_rom(6'd0);
    dg_rx_w     = r_blk;
    dg_rx_state = r_ist;
    if (r_state == S_RUN) begin
      dg_k = k_rom(r_rnd);
      if (r_rnd != 6'd0) begin
        dg_rx_w     = dg_tx_w;
        dg_rx_state = dg_tx_state;
      end else begin
        dg_rx_w     = r_blk;
        dg_rx_state = r_ist;
      end
    end else begin
      dg_k        = k_rom(6'd0);
      dg_rx_w     = r_blk;
      dg_rx_state = r_ist;
    end
  end

  // Sequencer FSM with registered digest and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rnd        <= 6'd0;
      r_blk        <= 512'd0;
      r_ist        <= 256'd0;
      r_out_valid  <= 1'b0;
      r_out_digest <= 256'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_blk   <= in_block;
            r_ist   <= in_state;
            r_rnd   <= 6'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_rnd == 6'd63) begin
            r_rnd   <= 6'd0;
            r_state <= S_FINISH;
          end else begin
            r_rnd <= r_rnd + 6'd1;
          end
        end
        S_FINISH: begin
          r_out_digest <= w_final;
          r_out_valid  <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
